vx_wb_scoreboard: RTL and testbench
===================================

Name: vx_wb_scoreboard

Overview:
- Per-warp register-busy tracker. Sits between the instruction buffer (upstream) and dispatch (downstream).
- Closes the loop with the writeback stage, which is its consumer-side neighbour.
- Marks an instruction's destination register busy when it issues, and releases it when writeback fires with end-of-packet.
- Blocks issue on RAW/WAW hazards, reports per-warp idle status, and runs a stall watchdog.

Parameters:
- NUM_WARPS, 4, number of warps; NW_WIDTH = max(1, log2(NUM_WARPS)).
- NUM_REGS, 64, architectural registers per warp (32 integer + 32 FP); NR_BITS = log2(NUM_REGS).
- STALL_TIMEOUT, 100000, consecutive hazard-stall cycles before the watchdog trips.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ibuf_valid  in  1  upstream instruction valid
- ibuf_wid  in  NW_WIDTH  warp id
- ibuf_wb  in  1  instruction writes rd
- ibuf_rd  in  NR_BITS  destination register
- ibuf_rs1  in  NR_BITS  source 1
- ibuf_rs2  in  NR_BITS  source 2
- ibuf_rs3  in  NR_BITS  source 3 (FMA)
- ibuf_ready  out  1  issue accepted
- disp_valid  out  1  hazard-free instruction to dispatch
- disp_ready  in  1  dispatch can accept
- wb_valid  in  1  writeback valid
- wb_wid  in  NW_WIDTH  writeback warp
- wb_rd  in  NR_BITS  writeback register
- wb_eop  in  1  last packet of the instruction
- wb_ready  out  1  writeback accepted
- warp_idle  out  NUM_WARPS  warp has no busy registers
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- State: inuse[NUM_WARPS][NUM_REGS], stall_cnt, timeout_r. Reset (reset==0, async) clears all three.
- While reset is asserted: ibuf_ready=0, disp_valid=0, wb_ready=0, warp_idle=all 1s, stall_timeout=0.
- hazard = inuse[ibuf_wid][rs1] | inuse[ibuf_wid][rs2] | inuse[ibuf_wid][rs3] | (ibuf_wb & inuse[ibuf_wid][rd]).
  - hazard is computed from registered state only.
  - No same-cycle release bypass: a register released in cycle N unblocks issue in cycle N+1.
- Issue handshake:
  - disp_valid = ibuf_valid & ~hazard.
  - ibuf_ready = disp_ready & ~hazard.
  - issue_fire = ibuf_valid & ibuf_ready. Both outputs are combinational; the handshake adds 0 cycles of latency.
- Set: on issue_fire with ibuf_wb and ibuf_rd != 0, inuse[ibuf_wid][ibuf_rd] <= 1. Register 0 (x0) is never tracked and reads as not busy. FP register 32 is tracked normally.
- Release:
  - wb_ready is tied to 1 out of reset; writeback never stalls.
  - On wb_valid & wb_eop, inuse[wb_wid][wb_rd] <= 0.
  - Packets without eop (multi-packet instructions) do not release.
- Simultaneous set and release, different (wid, rd): both take effect. Same (wid, rd): the set wins.
- Illegal events (simulation assertions, no RTL recovery):
  - Release of a register that is not busy.
  - Set of a register already busy. This cannot happen because of the WAW check.
- warp_idle[w] = ~|inuse[w], registered view.
- Watchdog:
  - stall_cnt increments each cycle ibuf_valid & hazard, and clears on any cycle without that condition.
  - When stall_cnt reaches STALL_TIMEOUT-1 while still stalled, timeout_r is set. It is sticky until reset.
  - stall_cnt saturates and never wraps.
  - stall_timeout = timeout_r.
- Reset mid-operation: all busy bits drop immediately. A writeback arriving after reset for a pre-reset instruction hits the not-busy assertion, which is expected only in reset tests and must be masked there.

Decomposition:
- Shared package: NW_WIDTH, NR_BITS, NUM_REGS, and the x0 index constant.
- One sub-module, vx_stall_watchdog: saturating counter plus sticky flag, parameterised by STALL_TIMEOUT. Its inputs are stall_cond, clk and reset; its output is the timeout flag.
- Busy table and hazard logic stay in the top level.

Test Plan:
- Warp 0 issues rd=5 with wb=1, then issues rs1=5 the next cycle -> second instruction sees disp_valid=0 and ibuf_ready=0 until the cycle after wb_valid/wb_eop with wb_rd=5.
- Release of w1/r7 and issue of w1 writing r7 in the same cycle -> inuse[1][7] stays 1 and the issue is blocked for WAW the next cycle.
- Issue with rd=0, wb=1 -> no busy bit set, warp_idle[0] stays 1, and a following rs1=0 reader issues immediately.
- Multi-packet writeback: w2/r10 with eop=0 then eop=1 -> r10 remains busy after the first packet and is freed only after the second.
- Hazard held for STALL_TIMEOUT cycles with STALL_TIMEOUT=8 -> stall_timeout rises on cycle 8 of the stall and stays 1 after the hazard clears, until reset.
- Busy registers in 3 warps, then reset pulled low mid-run -> all outputs take reset values asynchronously, and after release warp_idle=4'b1111 with no hazards.

Source files
------------

// File: rtl/vx_wb_scoreboard_pkg.sv
// Shared sizing constants for the writeback scoreboard: warp/register counts,
// index widths, and the hard-wired zero register that is never tracked.
package vx_wb_scoreboard_pkg;

    localparam int NUM_WARPS = 4;
    localparam int NUM_REGS  = 64;
    localparam int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NR_BITS   = $clog2(NUM_REGS);

    localparam logic [NR_BITS-1:0] X0_REG = '0;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [NR_BITS-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/vx_stall_watchdog.sv
// Counts consecutive hazard-stall cycles and raises a sticky flag once the
// stall has lasted STALL_TIMEOUT cycles; the counter saturates instead of wrapping.
module vx_stall_watchdog #(
    parameter int STALL_TIMEOUT = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic stall_cond,
    output logic timeout
);

    localparam int              CW       = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STALL_TIMEOUT - 1);

    logic [CW-1:0] r_stall_cnt;
    logic          r_timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else if (stall_cond) begin
            if (r_stall_cnt == CNT_LAST) begin
                r_timeout <= 1'b1;
            end else begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
        end else begin
            r_stall_cnt <= '0;
        end
    end

    assign timeout = r_timeout;

endmodule

// File: rtl/vx_wb_scoreboard.sv
// Per-warp register busy table between the instruction buffer and dispatch:
// blocks RAW/WAW hazards, releases on end-of-packet writeback, reports idle warps.
module vx_wb_scoreboard
    import vx_wb_scoreboard_pkg::*;
#(
    parameter int STALL_TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibuf_valid,
    input  logic [NW_WIDTH-1:0]  ibuf_wid,
    input  logic                 ibuf_wb,
    input  logic [NR_BITS-1:0]   ibuf_rd,
    input  logic [NR_BITS-1:0]   ibuf_rs1,
    input  logic [NR_BITS-1:0]   ibuf_rs2,
    input  logic [NR_BITS-1:0]   ibuf_rs3,
    output logic                 ibuf_ready,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    input  logic                 wb_valid,
    input  logic [NW_WIDTH-1:0]  wb_wid,
    input  logic [NR_BITS-1:0]   wb_rd,
    input  logic                 wb_eop,
    output logic                 wb_ready,
    output logic [NUM_WARPS-1:0] warp_idle,
    output logic                 stall_timeout
);

    logic [NUM_REGS-1:0] r_inuse [NUM_WARPS];

    logic [NUM_REGS-1:0] w_cur;
    logic                w_hazard;
    logic                w_issue_fire;
    logic                w_set_en;
    logic                w_clr_en;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    // Hazard looks only at registered state, so a release unblocks one cycle later.
    assign w_cur    = r_inuse[ibuf_wid];
    assign w_hazard = w_cur[ibuf_rs1] | w_cur[ibuf_rs2] | w_cur[ibuf_rs3]
                    | (ibuf_wb & w_cur[ibuf_rd]);

    assign disp_valid   = reset & ibuf_valid & ~w_hazard;
    assign ibuf_ready   = reset & disp_ready & ~w_hazard;
    assign wb_ready     = reset;
    assign w_issue_fire = ibuf_valid & ibuf_ready;

    assign w_set_en   = w_issue_fire & ibuf_wb & (ibuf_rd != X0_REG);
    assign w_clr_en   = wb_valid & wb_eop;
    assign w_set_mask = reg_onehot(ibuf_rd);
    assign w_clr_mask = reg_onehot(wb_rd);

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            logic w_set_here;
            logic w_clr_here;

            assign w_set_here = w_set_en & (ibuf_wid == NW_WIDTH'(gi));
            assign w_clr_here = w_clr_en & (wb_wid == NW_WIDTH'(gi));

            // Clear first, then set, so a same-register collision leaves it busy.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_inuse[gi] <= '0;
                end else begin
                    r_inuse[gi] <= (r_inuse[gi] & ~({NUM_REGS{w_clr_here}} & w_clr_mask))
                                 | ({NUM_REGS{w_set_here}} & w_set_mask);
                end
            end

            assign warp_idle[gi] = ~|r_inuse[gi];
        end
    endgenerate

    vx_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .reset      (reset),
        .stall_cond (ibuf_valid & w_hazard),
        .timeout    (stall_timeout)
    );

    // A release colliding with a set of the same register is the defined set-wins case.
    a_release_busy: assert property (@(posedge clk) disable iff (!reset)
        (w_clr_en && (wb_rd != X0_REG)
         && !(w_set_en && (ibuf_wid == wb_wid) && (ibuf_rd == wb_rd)))
        |-> r_inuse[wb_wid][wb_rd]);

    a_set_free: assert property (@(posedge clk) disable iff (!reset)
        w_set_en |-> !r_inuse[ibuf_wid][ibuf_rd]);

endmodule

// File: tb/tb_vx_wb_scoreboard.sv
// Directed bench for vx_wb_scoreboard: a per-cycle vector table for hazards and
// release ordering, plus hand sequences for the watchdog and asynchronous reset.
module tb_vx_wb_scoreboard;

    logic       clk;
    logic       reset;
    logic       ibuf_valid;
    logic [1:0] ibuf_wid;
    logic       ibuf_wb;
    logic [5:0] ibuf_rd;
    logic [5:0] ibuf_rs1;
    logic [5:0] ibuf_rs2;
    logic [5:0] ibuf_rs3;
    logic       ibuf_ready;
    logic       disp_valid;
    logic       disp_ready;
    logic       wb_valid;
    logic [1:0] wb_wid;
    logic [5:0] wb_rd;
    logic       wb_eop;
    logic       wb_ready;
    logic [3:0] warp_idle;
    logic       stall_timeout;

    int n_checks;
    int n_errors;

    vx_wb_scoreboard #(
        .STALL_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ibuf_valid    (ibuf_valid),
        .ibuf_wid      (ibuf_wid),
        .ibuf_wb       (ibuf_wb),
        .ibuf_rd       (ibuf_rd),
        .ibuf_rs1      (ibuf_rs1),
        .ibuf_rs2      (ibuf_rs2),
        .ibuf_rs3      (ibuf_rs3),
        .ibuf_ready    (ibuf_ready),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .wb_valid      (wb_valid),
        .wb_wid        (wb_wid),
        .wb_rd         (wb_rd),
        .wb_eop        (wb_eop),
        .wb_ready      (wb_ready),
        .warp_idle     (warp_idle),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [1:0] wid;
        logic       wb;
        logic [5:0] rd;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic [5:0] rs3;
        logic       dr;
        logic       wv;
        logic [1:0] wwid;
        logic [5:0] wrd;
        logic       weop;
        logic       e_dv;
        logic       e_rdy;
        logic [3:0] e_idle;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic iv, input logic [1:0] wid, input logic wb, input logic [5:0] rd,
        input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rs3, input logic dr,
        input logic wv, input logic [1:0] wwid, input logic [5:0] wrd, input logic weop,
        input logic e_dv, input logic e_rdy, input logic [3:0] e_idle);
        vec_t v;
        v.iv = iv;   v.wid = wid;   v.wb = wb;     v.rd = rd;
        v.rs1 = rs1; v.rs2 = rs2;   v.rs3 = rs3;   v.dr = dr;
        v.wv = wv;   v.wwid = wwid; v.wrd = wrd;   v.weop = weop;
        v.e_dv = e_dv; v.e_rdy = e_rdy; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic iv, input logic [1:0] wid, input logic wb,
                             input logic [5:0] rd, input logic [5:0] rs1,
                             input logic [5:0] rs2, input logic [5:0] rs3, input logic dr);
        ibuf_valid = iv; ibuf_wid = wid; ibuf_wb = wb; ibuf_rd = rd;
        ibuf_rs1 = rs1;  ibuf_rs2 = rs2; ibuf_rs3 = rs3; disp_ready = dr;
    endtask

    task automatic set_wb(input logic wv, input logic [1:0] wid, input logic [5:0] rd,
                          input logic eop);
        wb_valid = wv; wb_wid = wid; wb_rd = rd; wb_eop = eop;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //              iv wid wb rd  rs1 rs2 rs3 dr | wv ww wrd eop | dv rdy idle
        tbl[0]  = mk(0, 0, 0, 0,  0,  0,  0,  1,  0, 0, 0,  0,  0, 1, 4'b1111);
        tbl[1]  = mk(1, 0, 1, 5,  1,  2,  3,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[2]  = mk(1, 0, 1, 6,  5,  0,  0,  1,  0, 0, 0,  0,  0, 0, 4'b1110);
        tbl[3]  = mk(1, 0, 1, 6,  5,  0,  0,  1,  1, 0, 5,  1,  0, 0, 4'b1110);
        tbl[4]  = mk(1, 0, 1, 6,  5,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[5]  = mk(1, 0, 1, 0,  0,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1110);
        tbl[6]  = mk(1, 0, 0, 0,  0,  0,  0,  1,  1, 0, 6,  1,  1, 1, 4'b1110);
        tbl[7]  = mk(1, 3, 1, 0,  0,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[8]  = mk(0, 3, 0, 0,  0,  0,  0,  1,  0, 0, 0,  0,  0, 1, 4'b1111);
        tbl[9]  = mk(1, 2, 1, 10, 0,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[10] = mk(0, 0, 0, 0,  0,  0,  0,  1,  1, 2, 10, 0,  0, 1, 4'b1011);
        tbl[11] = mk(1, 2, 0, 0,  0,  10, 0,  1,  1, 2, 10, 1,  0, 0, 4'b1011);
        tbl[12] = mk(1, 2, 0, 0,  0,  10, 0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[13] = mk(1, 1, 1, 7,  0,  0,  0,  1,  1, 1, 7,  1,  1, 1, 4'b1111);
        tbl[14] = mk(1, 1, 1, 7,  0,  0,  0,  1,  0, 0, 0,  0,  0, 0, 4'b1101);
        tbl[15] = mk(0, 1, 0, 0,  0,  0,  0,  1,  1, 1, 7,  1,  0, 1, 4'b1101);
        tbl[16] = mk(1, 1, 1, 7,  0,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[17] = mk(0, 1, 0, 0,  0,  0,  0,  1,  1, 1, 7,  1,  0, 1, 4'b1101);
        tbl[18] = mk(1, 0, 1, 9,  0,  0,  0,  0,  0, 0, 0,  0,  1, 0, 4'b1111);
        tbl[19] = mk(1, 0, 0, 0,  0,  0,  9,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[20] = mk(1, 3, 1, 32, 0,  0,  0,  1,  0, 0, 0,  0,  1, 1, 4'b1111);
        tbl[21] = mk(1, 3, 0, 0,  0,  0,  32, 1,  0, 0, 0,  0,  0, 0, 4'b0111);
        tbl[22] = mk(1, 2, 0, 0,  32, 0,  0,  1,  1, 3, 32, 1,  1, 1, 4'b0111);
        tbl[23] = mk(0, 0, 0, 0,  0,  0,  0,  1,  0, 0, 0,  0,  0, 1, 4'b1111);

        // Reset held with a valid, ready request: outputs must still be gated.
        reset = 1'b0;
        set_issue(1, 0, 1, 5, 0, 0, 0, 1);
        set_wb(0, 0, 0, 0);
        #2;
        check("rst_ibuf_ready", 32'(ibuf_ready), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_wb_ready", 32'(wb_ready), 32'd0);
        check("rst_warp_idle", 32'(warp_idle), 32'hF);
        check("rst_stall_timeout", 32'(stall_timeout), 32'd0);
        set_issue(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_wb_ready", 32'(wb_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            set_issue(tbl[i].iv, tbl[i].wid, tbl[i].wb, tbl[i].rd,
                      tbl[i].rs1, tbl[i].rs2, tbl[i].rs3, tbl[i].dr);
            set_wb(tbl[i].wv, tbl[i].wwid, tbl[i].wrd, tbl[i].weop);
            #1;
            $display("vec %0d: iv=%0b w%0d wb=%0b rd=%0d rs=%0d/%0d/%0d dr=%0b | wbv=%0b w%0d r%0d eop=%0b | dv=%0b rdy=%0b idle=%b",
                     i, tbl[i].iv, tbl[i].wid, tbl[i].wb, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                     tbl[i].rs3, tbl[i].dr, tbl[i].wv, tbl[i].wwid, tbl[i].wrd, tbl[i].weop,
                     disp_valid, ibuf_ready, warp_idle);
            check($sformatf("vec%0d_disp_valid", i), 32'(disp_valid), 32'(tbl[i].e_dv));
            check($sformatf("vec%0d_ibuf_ready", i), 32'(ibuf_ready), 32'(tbl[i].e_rdy));
            check($sformatf("vec%0d_warp_idle", i), 32'(warp_idle), 32'(tbl[i].e_idle));
            tick();
        end
        set_wb(0, 0, 0, 0);
        check("table_no_timeout", 32'(stall_timeout), 32'd0);

        // Watchdog: w0/r5 busy, then a reader of r5 held valid for 8 cycles.
        set_issue(1, 0, 1, 5, 0, 0, 0, 1);
        tick();
        set_issue(1, 0, 0, 0, 5, 0, 0, 1);
        #1;
        check("wd_stalled", 32'(disp_valid), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            $display("watchdog stall cycle %0d: stall_timeout=%0b", i, stall_timeout);
            check($sformatf("wd_after_%0d", i), 32'(stall_timeout), (i >= 8) ? 32'd1 : 32'd0);
        end
        set_issue(0, 0, 0, 0, 0, 0, 0, 1);
        set_wb(1, 0, 5, 1);
        tick();
        set_wb(0, 0, 0, 0);
        tick();
        tick();
        check("wd_sticky", 32'(stall_timeout), 32'd1);
        check("wd_idle_after_release", 32'(warp_idle), 32'hF);

        // Busy registers in three warps, then asynchronous reset mid-cycle.
        set_issue(1, 0, 1, 1, 0, 0, 0, 1);
        tick();
        set_issue(1, 1, 1, 2, 0, 0, 0, 1);
        tick();
        set_issue(1, 2, 1, 3, 0, 0, 0, 1);
        tick();
        set_issue(1, 0, 0, 0, 1, 0, 0, 1);
        #1;
        check("mid_warp_idle", 32'(warp_idle), 32'b1000);
        check("mid_hazard", 32'(disp_valid), 32'd0);
        reset = 1'b0;
        #1;
        $display("async reset asserted: idle=%b dv=%0b rdy=%0b wbr=%0b to=%0b",
                 warp_idle, disp_valid, ibuf_ready, wb_ready, stall_timeout);
        check("arst_warp_idle", 32'(warp_idle), 32'hF);
        check("arst_disp_valid", 32'(disp_valid), 32'd0);
        check("arst_ibuf_ready", 32'(ibuf_ready), 32'd0);
        check("arst_wb_ready", 32'(wb_ready), 32'd0);
        check("arst_stall_timeout", 32'(stall_timeout), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("rel_disp_valid", 32'(disp_valid), 32'd1);
        check("rel_ibuf_ready", 32'(ibuf_ready), 32'd1);
        check("rel_wb_ready", 32'(wb_ready), 32'd1);
        check("rel_warp_idle", 32'(warp_idle), 32'hF);
        set_issue(1, 2, 0, 0, 3, 0, 0, 1);
        #1;
        check("rel_w2_no_hazard", 32'(disp_valid), 32'd1);
        tick();
        set_issue(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        check("rel_final_idle", 32'(warp_idle), 32'hF);
        check("rel_final_timeout", 32'(stall_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
